// File: rtl/rpc_net_mux_pkg.sv
// Shared RPC/NIC type definitions used by the multi-channel network mux.
// Holds the RPC packet layout, the connection-manager and network word
// formats, the optional statistics record and the conn_id field position.
package rpc_net_mux_pkg;

  // Largest channel count one mux instance is built for.
  localparam int RPC_NET_MUX_MAX_CH = 8;

  typedef struct packed {
    logic [7:0]  conn_id;
    logic [7:0]  fn_id;
    logic [15:0] req_id;
  } RpcHdr;

  typedef struct packed {
    RpcHdr       hdr;
    logic [31:0] args;
  } RpcPckt;

  localparam int RPC_PCKT_W    = $bits(RpcPckt);
  localparam int NET_PAYLOAD_W = 128;

  // conn_id is the most significant byte of an RpcPckt, and therefore of the
  // low RPC_PCKT_W bits of a network payload.
  localparam int RPC_CONN_ID_W   = 8;
  localparam int RPC_CONN_ID_LSB = RPC_PCKT_W - RPC_CONN_ID_W;

  typedef struct packed {
    logic        valid;
    logic [31:0] net_addr;
    logic [23:0] remote_qp_num;
    logic [15:0] p_key;
    logic [31:0] q_key;
    RpcPckt      rpc_data;
  } CManagerNetRpcIf;

  typedef struct packed {
    logic                     valid;
    logic [31:0]              addr_tpl;
    logic [23:0]              remote_qp_num;
    logic [15:0]              p_key;
    logic [31:0]              q_key;
    logic [NET_PAYLOAD_W-1:0] payload;
  } NetworkIf;

  localparam int NET_W = $bits(NetworkIf);

  typedef struct packed {
    logic [31:0] tx_cnt;
    logic [31:0] rx_cnt;
  } RpcNetMuxStats;

endpackage

// File: rtl/rpc_net_fifo.sv
// Generic synchronous first-word-fall-through FIFO. Storage is a register
// array; the head entry is read straight out of it so a written word is
// visible on head the cycle after the push. Pointers carry one extra wrap
// bit so full and empty are told apart without an occupancy counter.
// A push is accepted only when not full, regardless of a same-cycle pop.
module rpc_net_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Full when the indices match but the wrap bits differ; empty when equal.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    head      = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Pointer advance; reset discards every buffered word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/rpc_net_mux.sv
// Multi-channel RPC network serializer/deserializer.
// TX: round-robin arbitration over the per-channel requests, one grant per
// cycle while the TX FIFO has room; granted RPCs are wrapped into network
// words and streamed out of a FWFT FIFO under downstream backpressure.
// RX: each inbound packet is steered, one cycle later, to the channel picked
// by the low bits of its conn_id; ids with no matching channel are dropped,
// counted and flag the sticky error.
// Optional feature macro: RPC_NET_MUX_STATS_EN adds per-channel 32-bit
// wrapping TX-accept and RX-delivery counters (stats_tx_cnt, stats_rx_cnt).
module rpc_net_mux
  import rpc_net_mux_pkg::*;
#(
  parameter int NIC_ID     = 0,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  CManagerNetRpcIf   tx_in [NUM_CH],
  output logic [NUM_CH-1:0] tx_ready_out,
  output NetworkIf          network_tx_out,
  input  logic              network_tx_ready_in,
  input  NetworkIf          network_rx_in,
  output CManagerNetRpcIf   rx_out [NUM_CH],
  output logic [15:0]       rx_drop_cnt,
  output logic              error
`ifdef RPC_NET_MUX_STATS_EN
  ,
  output logic [31:0]       stats_tx_cnt [NUM_CH],
  output logic [31:0]       stats_rx_cnt [NUM_CH]
`endif
);

  logic [CH_W-1:0]  last_grant_r;
  logic             grant_valid_s;
  logic [CH_W-1:0]  grant_idx_s;
  logic             arb_en_s;
  int               cand_s;

  NetworkIf         push_word_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [NET_W-1:0] fifo_head_s;
  logic             fifo_pop_s;
  logic             push_overrun_s;

  logic [CH_W-1:0]  rx_idx_s;
  logic             rx_hit_s;
  logic             rx_drop_s;
  CManagerNetRpcIf  rx_word_s;
  logic             unused_s;

  // Bits of the inbound word that steering never looks at, plus the id
  // parameter that only matters for simulation messages.
  assign unused_s = ^{network_rx_in.payload[NET_PAYLOAD_W-1:RPC_PCKT_W], 32'(NIC_ID)};

  // Arbitration is suspended in reset and whenever the FIFO is full; a pop
  // in the same cycle does not reopen it, so the grant resumes one cycle
  // after the pop that frees a slot.
  always_comb begin
    if (reset || fifo_full_s) begin
      arb_en_s = 1'b0;
    end else begin
      arb_en_s = 1'b1;
    end
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_s = (int'(last_grant_r) + 1 + k) % NUM_CH;
      if (arb_en_s && !grant_valid_s && tx_in[cand_s].valid) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = CH_W'(cand_s);
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // One-hot accept strobe for the granted channel only.
  always_comb begin
    tx_ready_out = '0;
    if (grant_valid_s) begin
      tx_ready_out[grant_idx_s] = 1'b1;
    end else begin
      tx_ready_out = '0;
    end
  end

  // Remember the winner so the next search starts after it; hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= CH_W'(NUM_CH - 1);
    end else if (grant_valid_s) begin
      last_grant_r <= grant_idx_s;
    end
  end

  // Wrap the granted channel's RPC into a network word, upper payload zero.
  always_comb begin
    push_word_s                          = '0;
    push_word_s.valid                    = 1'b1;
    push_word_s.addr_tpl                 = tx_in[grant_idx_s].net_addr;
    push_word_s.remote_qp_num            = tx_in[grant_idx_s].remote_qp_num;
    push_word_s.p_key                    = tx_in[grant_idx_s].p_key;
    push_word_s.q_key                    = tx_in[grant_idx_s].q_key;
    push_word_s.payload[RPC_PCKT_W-1:0]  = tx_in[grant_idx_s].rpc_data;
  end

  // Guard against a push reaching a full FIFO; the arbiter should make
  // this impossible, so any occurrence is latched as an error.
  always_comb begin
    if (grant_valid_s && fifo_full_s) begin
      push_overrun_s = 1'b1;
    end else begin
      push_overrun_s = 1'b0;
    end
  end

  // Downstream pop handshake on the visible head word.
  always_comb begin
    if (!fifo_empty_s && network_tx_ready_in) begin
      fifo_pop_s = 1'b1;
    end else begin
      fifo_pop_s = 1'b0;
    end
  end

  rpc_net_fifo #(
    .WIDTH (NET_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (grant_valid_s),
    .pop   (fifo_pop_s),
    .wdata (push_word_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .head  (fifo_head_s)
  );

  // Present the FIFO head, forced to all-zero while nothing is buffered.
  always_comb begin
    if (fifo_empty_s) begin
      network_tx_out = '0;
    end else begin
      network_tx_out = fifo_head_s;
    end
  end

  // Decode the destination channel from the low conn_id bits.
  always_comb begin
    rx_idx_s = network_rx_in.payload[RPC_CONN_ID_LSB +: CH_W];
    if (network_rx_in.valid && (int'(rx_idx_s) < NUM_CH)) begin
      rx_hit_s  = 1'b1;
      rx_drop_s = 1'b0;
    end else if (network_rx_in.valid) begin
      rx_hit_s  = 1'b0;
      rx_drop_s = 1'b1;
    end else begin
      rx_hit_s  = 1'b0;
      rx_drop_s = 1'b0;
    end
  end

  // Unwrap the inbound network word into the connection-manager format.
  always_comb begin
    rx_word_s               = '0;
    rx_word_s.valid         = 1'b1;
    rx_word_s.net_addr      = network_rx_in.addr_tpl;
    rx_word_s.remote_qp_num = network_rx_in.remote_qp_num;
    rx_word_s.p_key         = network_rx_in.p_key;
    rx_word_s.q_key         = network_rx_in.q_key;
    rx_word_s.rpc_data      = network_rx_in.payload[RPC_PCKT_W-1:0];
  end

  // Single-cycle RX delivery pulse, drop counting and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        rx_out[i] <= '0;
      end
      rx_drop_cnt <= 16'h0000;
      error       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rx_hit_s && (rx_idx_s == CH_W'(i))) begin
          rx_out[i] <= rx_word_s;
        end else begin
          rx_out[i] <= '0;
        end
      end
      if (rx_drop_s && (rx_drop_cnt != 16'hFFFF)) begin
        rx_drop_cnt <= rx_drop_cnt + 16'd1;
      end
      error <= error | rx_drop_s | push_overrun_s;
    end
  end

`ifdef RPC_NET_MUX_STATS_EN
  RpcNetMuxStats stats_r [NUM_CH];

  // Per-channel wrapping counters of accepted TX and delivered RX packets.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        stats_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (tx_ready_out[i]) begin
          stats_r[i].tx_cnt <= stats_r[i].tx_cnt + 32'd1;
        end
        if (rx_hit_s && (rx_idx_s == CH_W'(i))) begin
          stats_r[i].rx_cnt <= stats_r[i].rx_cnt + 32'd1;
        end
      end
    end
  end

  // Expose the counter record as the two flat stats ports.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      stats_tx_cnt[i] = stats_r[i].tx_cnt;
      stats_rx_cnt[i] = stats_r[i].rx_cnt;
    end
  end
`else
  // Statistics build option disabled: no counters or stats ports exist.
`endif

endmodule

// File: tb/tb_rpc_net_mux.sv
// Self-checking bench for rpc_net_mux. A queue-based model of the TX path and
// a per-channel expectation of the RX path are compared against a 4-channel
// instance on every falling edge; directed scenarios add hand-computed
// literal checks. A second, 3-channel instance covers the RX drop path.
module tb_rpc_net_mux;
  import rpc_net_mux_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  CManagerNetRpcIf tx_in [4];
  logic [3:0]      tx_ready;
  NetworkIf        ntx;
  logic            ntx_ready;
  NetworkIf        nrx;
  CManagerNetRpcIf rx_out [4];
  logic [15:0]     drop_cnt;
  logic            err;

  CManagerNetRpcIf tx3 [3];
  logic [2:0]      tx_ready3;
  NetworkIf        ntx3;
  logic            ntx_ready3;
  NetworkIf        nrx3;
  CManagerNetRpcIf rx3 [3];
  logic [15:0]     drop3;
  logic            err3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rpc_net_mux #(.NIC_ID(0), .NUM_CH(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .tx_in(tx_in), .tx_ready_out(tx_ready),
    .network_tx_out(ntx), .network_tx_ready_in(ntx_ready),
    .network_rx_in(nrx), .rx_out(rx_out), .rx_drop_cnt(drop_cnt), .error(err)
  );

  rpc_net_mux #(.NIC_ID(1), .NUM_CH(3), .FIFO_DEPTH(8)) dut3 (
    .clk(clk), .reset(reset), .tx_in(tx3), .tx_ready_out(tx_ready3),
    .network_tx_out(ntx3), .network_tx_ready_in(ntx_ready3),
    .network_rx_in(nrx3), .rx_out(rx3), .rx_drop_cnt(drop3), .error(err3)
  );

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic CManagerNetRpcIf mk_rpc(input logic [7:0] ch, input logic [7:0] n);
    CManagerNetRpcIf r;
    r = '0;
    r.valid                 = 1'b1;
    r.net_addr              = {16'hA000, ch, n};
    r.remote_qp_num         = {16'h1000, ch};
    r.p_key                 = {8'h80, ch};
    r.q_key                 = {16'h1111, ch, n};
    r.rpc_data.hdr.conn_id  = ch;
    r.rpc_data.hdr.fn_id    = n;
    r.rpc_data.hdr.req_id   = {ch, n};
    r.rpc_data.args         = {16'hDEAD, 8'h00, n};
    return r;
  endfunction

  function automatic NetworkIf mk_net(input logic [7:0] conn, input logic [7:0] n);
    NetworkIf w;
    RpcPckt   p;
    p.hdr.conn_id   = conn;
    p.hdr.fn_id     = n;
    p.hdr.req_id    = 16'h5A5A;
    p.args          = {16'hCAFE, 8'h00, n};
    w               = '0;
    w.valid         = 1'b1;
    w.addr_tpl      = {16'hB000, 8'h00, n};
    w.remote_qp_num = {16'h2000, conn};
    w.p_key         = 16'h4000;
    w.q_key         = {16'h2222, 8'h00, n};
    w.payload       = {64'h0, p};
    return w;
  endfunction

  // Reference model: expected words in a queue, expected RX per channel.
  NetworkIf        mq[$];
  int              m_last = 3;
  CManagerNetRpcIf m_rx [4];
  bit              m_on = 1'b0;

  always @(negedge clk) begin : model_p
    logic [3:0]      e_rdy;
    int              g;
    int              c;
    NetworkIf        e_out;
    NetworkIf        w;
    RpcPckt          r;
    e_rdy = 4'b0000;
    g = -1;
    if (!reset && mq.size() < 8) begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (g < 0 && tx_in[c].valid) g = c;
      end
    end
    if (g >= 0) e_rdy[g] = 1'b1;
    e_out = (mq.size() > 0) ? mq[0] : '0;
    if (m_on) begin
      check("tx_ready", 256'(tx_ready), 256'(e_rdy));
      check("net_tx", 256'(ntx), 256'(e_out));
      for (int i = 0; i < 4; i++) check($sformatf("rx_out%0d", i), 256'(rx_out[i]), 256'(m_rx[i]));
      check("drop_err", 256'({drop_cnt, err}), 256'(17'h0));
    end
    if (reset) begin
      mq.delete();
      m_last = 3;
      for (int i = 0; i < 4; i++) m_rx[i] = '0;
      m_on = 1'b1;
    end else begin
      if (mq.size() > 0 && ntx_ready) void'(mq.pop_front());
      if (g >= 0) begin
        w = '0;
        w.valid = 1'b1;
        w.addr_tpl = tx_in[g].net_addr;
        w.remote_qp_num = tx_in[g].remote_qp_num;
        w.p_key = tx_in[g].p_key;
        w.q_key = tx_in[g].q_key;
        w.payload = {64'h0, tx_in[g].rpc_data};
        mq.push_back(w);
        m_last = g;
      end
      for (int i = 0; i < 4; i++) m_rx[i] = '0;
      if (nrx.valid) begin
        r = nrx.payload[63:0];
        c = int'(r.hdr.conn_id) % 4;
        m_rx[c].valid = 1'b1;
        m_rx[c].net_addr = nrx.addr_tpl;
        m_rx[c].remote_qp_num = nrx.remote_qp_num;
        m_rx[c].p_key = nrx.p_key;
        m_rx[c].q_key = nrx.q_key;
        m_rx[c].rpc_data = r;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_req(input logic on, input logic [7:0] n);
    for (int i = 0; i < 4; i++) tx_in[i] = on ? mk_rpc(8'(i), n + 8'(i)) : '0;
  endtask

  initial begin : stim
    int acc;
    int outs;
    reset = 1'b1;
    ntx_ready = 1'b0;
    ntx_ready3 = 1'b1;
    nrx = '0;
    nrx3 = '0;
    for (int i = 0; i < 4; i++) tx_in[i] = '0;
    for (int i = 0; i < 3; i++) tx3[i] = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_ntx", 256'(ntx), 256'h0);
    check("rst_drop", 256'(drop_cnt), 256'h0);
    check("rst_err", 256'(err), 256'h0);
    check("rst_ready", 256'(tx_ready), 256'h0);

    // Single request from channel 2
    tick();
    tx_in[2] = mk_rpc(8'd2, 8'd1);
    ntx_ready = 1'b1;
    @(negedge clk);
    check("ch2_ready", 256'(tx_ready), 256'(4'b0100));
    tick();
    tx_in[2] = '0;
    @(negedge clk);
    check("ch2_valid", 256'(ntx.valid), 256'h1);
    check("ch2_payload", 256'(ntx.payload), 256'(128'h0000_0000_0000_0000_0201_0201_DEAD_0001));
    check("ch2_qp", 256'({ntx.remote_qp_num, ntx.p_key, ntx.q_key}), 256'({24'h100002, 16'h8002, 32'h1111_0201}));
    tick();
    @(negedge clk);
    check("ch2_drained", 256'(ntx.valid), 256'h0);

    // Continuous requests from all channels after a fresh reset
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    all_req(1'b1, 8'h10);
    ntx_ready = 1'b1;
    outs = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("rr_grant%0d", k), 256'(tx_ready), 256'(4'b0001 << (k % 4)));
      if (ntx.valid) outs++;
      tick();
    end
    all_req(1'b0, 8'h00);
    @(negedge clk);
    if (ntx.valid) outs++;
    tick();
    @(negedge clk);
    check("rr_out_cnt", 256'(outs), 256'd8);

    // Backpressure fills the FIFO to exactly 8 words
    tick();
    ntx_ready = 1'b0;
    all_req(1'b1, 8'h20);
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      acc += $countones(tx_ready);
      tick();
    end
    @(negedge clk);
    check("bp_accepts", 256'(acc), 256'd8);
    check("bp_full_ready", 256'(tx_ready), 256'h0);
    tick();
    ntx_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_cycle", 256'(tx_ready), 256'h0);
    tick();
    ntx_ready = 1'b0;
    @(negedge clk);
    check("bp_reaccept", 256'($countones(tx_ready)), 256'd1);
    tick();
    all_req(1'b0, 8'h00);
    ntx_ready = 1'b1;
    repeat (10) tick();

    // RX steering on 4 channels and drop path on 3 channels
    nrx = mk_net(8'd6, 8'd3);
    nrx3 = mk_net(8'd3, 8'd4);
    tick();
    nrx = '0;
    nrx3 = mk_net(8'd1, 8'd5);
    @(negedge clk);
    check("rx2_valid", 256'(rx_out[2].valid), 256'h1);
    check("rx2_rpc", 256'(rx_out[2].rpc_data), 256'(64'h0603_5A5A_CAFE_0003));
    check("rx2_addr", 256'(rx_out[2].net_addr), 256'(32'hB000_0003));
    check("rx_others", 256'({rx_out[0], rx_out[1], rx_out[3]}), 256'h0);
    check("rx_drop_4ch", 256'(drop_cnt), 256'h0);
    check("drop3_cnt", 256'(drop3), 256'd1);
    check("drop3_err", 256'(err3), 256'h1);
    check("drop3_rx", 256'({rx3[0], rx3[1], rx3[2]}), 256'h0);
    tick();
    nrx3 = '0;
    @(negedge clk);
    check("good3_rx1", 256'(rx3[1].valid), 256'h1);
    check("good3_sticky", 256'({drop3, err3}), 256'({16'd1, 1'b1}));
    check("idle3_tx", 256'({tx_ready3, ntx3.valid}), 256'h0);

    // Reset in the middle of a buffered burst
    tick();
    ntx_ready = 1'b0;
    all_req(1'b1, 8'h30);
    repeat (5) tick();
    all_req(1'b0, 8'h00);
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("mid_rst_valid", 256'(ntx.valid), 256'h0);
    check("mid_rst_ready", 256'(tx_ready), 256'h0);
    check("mid_rst_err3", 256'({drop3, err3}), 256'h0);
    tick();
    reset = 1'b0;
    all_req(1'b1, 8'h40);
    @(negedge clk);
    check("post_rst_grant", 256'(tx_ready), 256'(4'b0001));
    tick();
    all_req(1'b0, 8'h00);
    ntx_ready = 1'b1;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
